// File: rtl/exp_in_debounce.sv
// rtl/exp_in_debounce.sv - expansion-connector input synchroniser, debouncer and event flags
module exp_in_debounce #(
  parameter int DWE = 8,
  parameter int DBW = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DWE-1:0]   pin_p_i,
  input  logic [DWE-1:0]   pin_n_i,
  input  logic [DBW-1:0]   deb_len_i,
  input  logic [2*DWE-1:0] rise_en_i,
  input  logic [2*DWE-1:0] fall_en_i,
  input  logic [2*DWE-1:0] clr_rise_i,
  input  logic [2*DWE-1:0] clr_fall_i,
  output logic [DWE-1:0]   dat_p_o,
  output logic [DWE-1:0]   dat_n_o,
  output logic [2*DWE-1:0] rise_o,
  output logic [2*DWE-1:0] fall_o,
  output logic             irq_o
);

  localparam int W = 2 * DWE;

  // N row occupies the upper half of every internal vector
  logic [W-1:0]   pins;
  logic [W-1:0]   s1;
  logic [W-1:0]   s2;
  logic [W-1:0]   stable;
  logic [W-1:0]   stable_nxt;
  logic [W-1:0]   evt;
  logic [W-1:0]   rise_set;
  logic [W-1:0]   fall_set;
  logic [W-1:0]   rise_q;
  logic [W-1:0]   fall_q;
  logic           irq_q;
  logic [DBW-1:0] cnt     [W];
  logic [DBW-1:0] cnt_nxt [W];

  assign pins = {pin_n_i, pin_p_i};

  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end

  // per-bit debounce decision: count while the synchronised level disagrees with the
  // committed level, commit once the count has reached the current debounce length
  always_comb begin
    stable_nxt = stable;
    evt        = '0;
    for (int i = 0; i < W; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] >= deb_len_i) begin
          stable_nxt[i] = s2[i];
          evt[i]        = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_set = evt & stable_nxt;
  assign fall_set = evt & ~stable_nxt;

  // committed levels and debounce counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // sticky event flags; a new event outranks a same-cycle clear so nothing is lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= (rise_q & ~clr_rise_i) | rise_set;
      fall_q <= (fall_q & ~clr_fall_i) | fall_set;
    end
  end

  // registered interrupt from the enabled flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |((rise_q & rise_en_i) | (fall_q & fall_en_i));
    end
  end

  assign dat_p_o = stable[DWE-1:0];
  assign dat_n_o = stable[W-1:DWE];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_exp_in_debounce.sv
// tb/tb_exp_in_debounce.sv - self-checking bench for exp_in_debounce
module tb_exp_in_debounce;

  localparam int DWE = 8;
  localparam int DBW = 20;
  localparam int W   = 2 * DWE;

  logic           clk = 1'b0;
  logic           rst;
  logic [DWE-1:0] pin_p, pin_n;
  logic [DBW-1:0] deb_len;
  logic [W-1:0]   rise_en, fall_en, clr_rise, clr_fall;
  logic [DWE-1:0] dat_p, dat_n;
  logic [W-1:0]   rise, fall;
  logic           irq;

  int tests = 0;
  int fails = 0;

  exp_in_debounce #(.DWE(DWE), .DBW(DBW)) dut (
    .clk_i(clk), .rst_i(rst), .pin_p_i(pin_p), .pin_n_i(pin_n), .deb_len_i(deb_len),
    .rise_en_i(rise_en), .fall_en_i(fall_en), .clr_rise_i(clr_rise), .clr_fall_i(clr_fall),
    .dat_p_o(dat_p), .dat_n_o(dat_n), .rise_o(rise), .fall_o(fall), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // reference model: pin history two samples deep, and for each bit the length of the
  // current run of samples that disagree with the committed level
  logic [W-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall;
  logic         m_irq;
  int           m_run [W];

  task automatic m_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic m_step();
    logic [W-1:0] ev_r, ev_f;
    ev_r = '0; ev_f = '0;
    m_irq = |((m_rise & rise_en) | (m_fall & fall_en));
    for (int i = 0; i < W; i++) begin
      if (m_d2[i] !== m_lvl[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > int'(deb_len)) begin
          m_lvl[i] = m_d2[i];
          m_run[i] = 0;
          if (m_d2[i]) ev_r[i] = 1'b1; else ev_f[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise = (m_rise & ~clr_rise) | ev_r;
    m_fall = (m_fall & ~clr_fall) | ev_f;
    m_d2 = m_d1;
    m_d1 = {pin_n, pin_p};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
  endtask

  task automatic clear_all();
    clr_rise = '1; clr_fall = '1;
    tick();
    clr_rise = '0; clr_fall = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({dat_n, dat_p, rise, fall, irq} !== '0) begin
      fails++; $display("FAIL reset_held: got dat=%h rise=%h fall=%h irq=%b, want all 0", {dat_n, dat_p}, rise, fall, irq);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({dat_n, dat_p, rise, fall, irq} !== '0) begin
      fails++; $display("FAIL reset_release: got dat=%h rise=%h fall=%h irq=%b, want all 0", {dat_n, dat_p}, rise, fall, irq);
    end
  endtask

  task automatic test_no_debounce();
    int lat;
    deb_len = '0;
    clear_all(); tick();
    rise_en = 16'h0001;
    pin_p[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (dat_p[0] === 1'b1) begin lat = k; break; end
    end
    tests++;
    if (lat != 3) begin fails++; $display("FAIL step_latency: got %0d edges, want 3", lat); end
    tests++;
    if (rise[0] !== 1'b1 || irq !== 1'b0) begin
      fails++; $display("FAIL step_flag: got rise0=%b irq=%b, want rise0=1 irq=0", rise[0], irq);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL step_irq: got %b, want 1", irq); end
    rise_en = '0; pin_p = '0;
    repeat (4) tick();
    clear_all(); tick();
  endtask

  task automatic test_glitch();
    logic ok;
    int lat;
    deb_len = 20'd10;
    pin_n[3] = 1'b1;
    repeat (5) tick();
    pin_n[3] = 1'b0;
    ok = 1'b1;
    repeat (25) begin
      tick();
      if (dat_n[3] !== 1'b0 || rise[11] !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL glitch_dropped: got dat_n3=%b rise11=%b, want 0 0", dat_n[3], rise[11]); end
    pin_n[3] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (dat_n[3] === 1'b1) begin lat = k; break; end
    end
    tests++;
    if (lat != 13) begin fails++; $display("FAIL clean_latency: got %0d edges, want 13", lat); end
    pin_n = '0; deb_len = '0;
    repeat (4) tick();
    clear_all(); tick();
  endtask

  task automatic test_bounce();
    int lat;
    logic early;
    deb_len = 20'd10;
    early = 1'b0;
    pin_p[1] = 1'b1;
    repeat (8) begin tick(); if (dat_p[1] !== 1'b0) early = 1'b1; end
    pin_p[1] = 1'b0;
    tick(); if (dat_p[1] !== 1'b0) early = 1'b1;
    pin_p[1] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (dat_p[1] === 1'b1) begin lat = k; break; end
    end
    tests++;
    if (early || lat != 13) begin
      fails++; $display("FAIL bounce: got early=%b latency=%0d, want early=0 latency=13", early, lat);
    end
    pin_p = '0; deb_len = '0;
    repeat (4) tick();
    clear_all(); tick();
  endtask

  task automatic test_collision();
    deb_len = '0;
    fall_en = 16'h0004;
    pin_p[2] = 1'b1;
    repeat (5) tick();
    clear_all(); tick();
    pin_p[2] = 1'b0;
    tick(); tick();
    clr_fall[2] = 1'b1;
    tick();
    clr_fall = '0;
    tests++;
    if (dat_p[2] !== 1'b0 || fall[2] !== 1'b1) begin
      fails++; $display("FAIL collision: got dat_p2=%b fall2=%b, want 0 1", dat_p[2], fall[2]);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL collision_irq: got %b, want 1", irq); end
    clr_fall[2] = 1'b1;
    tick();
    clr_fall = '0;
    tests++;
    if (fall[2] !== 1'b0 || irq !== 1'b1) begin
      fails++; $display("FAIL clear_flag: got fall2=%b irq=%b, want 0 1", fall[2], irq);
    end
    tick();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_drop: got %b, want 0", irq); end
    fall_en = '0;
    clear_all(); tick();
  endtask

  task automatic test_len_change();
    deb_len = 20'd1000;
    pin_p[5] = 1'b1;
    repeat (202) tick();
    tests++;
    if (dat_p[5] !== 1'b0) begin fails++; $display("FAIL len_hold: got %b, want 0", dat_p[5]); end
    deb_len = 20'd5;
    tick();
    tests++;
    if (dat_p[5] !== 1'b1 || rise[5] !== 1'b1) begin
      fails++; $display("FAIL len_shrink: got dat_p5=%b rise5=%b, want 1 1", dat_p[5], rise[5]);
    end
    pin_p = '0; deb_len = '0;
    repeat (4) tick();
    clear_all(); tick();
  endtask

  task automatic test_async_reset();
    int lat;
    deb_len = 20'd4;
    rise_en = '1;
    pin_p = '1; pin_n = '1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    m_reset();
    tests++;
    if ({dat_n, dat_p, rise, fall, irq} !== '0) begin
      fails++; $display("FAIL async_reset: got dat=%h rise=%h fall=%h irq=%b, want all 0", {dat_n, dat_p}, rise, fall, irq);
    end
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rise === '1) begin lat = k; break; end
    end
    tests++;
    if (lat != 7 || fall !== '0) begin
      fails++; $display("FAIL post_reset_rise: got latency=%0d fall=%h, want 7 0000", lat, fall);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL post_reset_irq: got %b, want 1", irq); end
    rise_en = '0; pin_p = '0; pin_n = '0; deb_len = '0;
    repeat (8) tick();
    clear_all(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) deb_len = DBW'($urandom_range(0, 6));
      if (c % 50 == 0) begin rise_en = W'($urandom); fall_en = W'($urandom); end
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, W - 1);
        if (b < DWE) pin_p[b] = ~pin_p[b]; else pin_n[b - DWE] = ~pin_n[b - DWE];
      end
      clr_rise = W'($urandom & $urandom & $urandom);
      clr_fall = W'($urandom & $urandom & $urandom);
      tick();
      tests++;
      if ({dat_n, dat_p} !== m_lvl || rise !== m_rise || fall !== m_fall || irq !== m_irq) begin
        fails++;
        $display("FAIL random cycle %0d: got dat=%h rise=%h fall=%h irq=%b, want dat=%h rise=%h fall=%h irq=%b",
                 c, {dat_n, dat_p}, rise, fall, irq, m_lvl, m_rise, m_fall, m_irq);
      end
    end
    clr_rise = '0; clr_fall = '0;
  endtask

  initial begin
    rst = 1'b1;
    pin_p = '0; pin_n = '0; deb_len = '0;
    rise_en = '0; fall_en = '0; clr_rise = '0; clr_fall = '0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_no_debounce();
    test_glitch();
    test_bounce();
    test_collision();
    test_len_change();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
